// File: rtl/dmem_block_reader_if.sv
// Bundle of the drain engine's control, memory read port and byte stream signals.
// The master side is the reader itself; the slave side is its environment.
interface dmem_block_reader_if #(
    parameter int VLEN = 128,
    parameter int NB_W = 8
);
    logic            start;
    logic [31:0]     base_addr;
    logic [NB_W-1:0] nblocks;
    logic [31:0]     rd_addr;
    logic            rd_en;
    logic            rd_vector;
    logic [VLEN-1:0] rd_data;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic            done;

    modport master (
        input  start, base_addr, nblocks, rd_data, tx_ready,
        output rd_addr, rd_en, rd_vector, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, base_addr, nblocks, rd_data, tx_ready,
        input  rd_addr, rd_en, rd_vector, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/dmem_block_reader.sv
// Fetches N consecutive 128-bit blocks from data memory and streams them out
// byte by byte (little-endian within each block) over a valid/ready channel.
module dmem_block_reader #(
    parameter int VLEN = 128,
    parameter int NB_W = 8
) (
    input  logic                clk,
    input  logic                clr,
    dmem_block_reader_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_addr;
    logic [NB_W-1:0] r_cnt;
    logic [3:0]      r_idx;
    logic [VLEN-1:0] r_sreg;
    logic            r_rd_en;
    logic            r_tx_valid;
    logic            r_busy;
    logic            r_done;

    // Outputs are decided one state ahead so each one is a flop, not decode logic.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'd0;
            r_cnt      <= {NB_W{1'b0}};
            r_idx      <= 4'd0;
            r_sreg     <= {VLEN{1'b0}};
            r_rd_en    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_addr <= {bus.base_addr[31:4], 4'b0000};
                        r_cnt  <= bus.nblocks;
                        r_busy <= 1'b1;
                        if (bus.nblocks == {NB_W{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            r_rd_en <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    r_sreg     <= bus.rd_data;
                    r_idx      <= 4'd0;
                    r_addr     <= r_addr + 32'd16;
                    r_cnt      <= r_cnt - {{(NB_W-1){1'b0}}, 1'b1};
                    r_rd_en    <= 1'b0;
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.tx_ready) begin
                        r_sreg <= {8'h00, r_sreg[VLEN-1:8]};
                        r_idx  <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_tx_valid <= 1'b0;
                            if (r_cnt != {NB_W{1'b0}}) begin
                                r_state <= ST_FETCH;
                                r_rd_en <= 1'b1;
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_rd_en    <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    // rd_vector mirrors rd_en: every access is full-width.
    assign bus.rd_addr   = r_addr;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_vector = r_rd_en;
    assign bus.tx_data   = r_sreg[7:0];
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_dmem_block_reader.sv
// Randomized bench for dmem_block_reader, checked against a queue-based model
// of the expected read addresses and byte stream.
module tb_dmem_block_reader;
    logic clk;
    logic clr;
    int   total;
    int   bad;
    int   ready_mode;
    int   pat;

    logic [31:0] addr_q[$];
    logic [7:0]  byte_q[$];

    dmem_block_reader_if #(.VLEN(128), .NB_W(8)) bus ();

    dmem_block_reader #(.VLEN(128), .NB_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: each byte is a function of its own byte address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ a[31:24];
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] a);
        logic [127:0] blk;
        for (int k = 0; k < 16; k++) blk[8*k +: 8] = mem_byte(a + 32'(k));
        return blk;
    endfunction

    assign bus.rd_data = mem_block(bus.rd_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_xfer(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = {base[31:4], 4'h0};
        for (int b = 0; b < n; b++) begin
            addr_q.push_back(a);
            for (int k = 0; k < 16; k++) byte_q.push_back(mem_byte(a + 32'(k)));
            a = a + 32'd16;
        end
    endtask

    // Sink readiness pattern, updated once per cycle.
    initial begin
        pat = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: bus.tx_ready = 1'b1;
                1: begin
                    bus.tx_ready = (pat == 0 || pat == 3);
                    pat = (pat + 1) % 4;
                end
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs with the model queues.
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_d;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (clr) begin
                prev_v = 1'b0;
            end else begin
                if (bus.rd_en) begin
                    chk("rd_vector", 32'(bus.rd_vector), 32'd1);
                    if (addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_read: got addr %h expected no read", bus.rd_addr);
                    end else begin
                        chk("rd_addr", bus.rd_addr, addr_q.pop_front());
                    end
                end else begin
                    chk("rd_vector_idle", 32'(bus.rd_vector), 32'd0);
                end
                if (prev_v && !prev_r) begin
                    chk("hold_valid", 32'(bus.tx_valid), 32'd1);
                    chk("hold_data", 32'(bus.tx_data), 32'(prev_d));
                end
                if (bus.tx_valid) begin
                    if (byte_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %h expected no byte", bus.tx_data);
                    end else begin
                        chk("tx_data", 32'(bus.tx_data), 32'(byte_q[0]));
                        if (bus.tx_ready) void'(byte_q.pop_front());
                    end
                end
                if (bus.done) begin
                    chk("done_bytes_left", 32'(byte_q.size()), 32'd0);
                    chk("done_reads_left", 32'(addr_q.size()), 32'd0);
                end
                prev_v = bus.tx_valid;
                prev_r = bus.tx_ready;
                prev_d = bus.tx_data;
            end
        end
    end

    // One transfer; inject >= 0 pulses a foreign start at that cycle.
    task automatic run_xfer(input logic [31:0] base, input int n, input int mode, input int inject);
        int c;
        int bound;
        ready_mode = mode;
        bound = 100 * n + 10;
        @(negedge clk);
        push_xfer(base, n);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.nblocks   = 8'(n);
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        #1;
        chk("busy_cycle1", 32'(bus.busy), 32'd1);
        chk("rd_en_cycle1", 32'(bus.rd_en), (n != 0) ? 32'd1 : 32'd0);
        while (!bus.done && c < bound) begin
            if (c == inject) begin
                bus.start     = 1'b1;
                bus.base_addr = 32'h200;
                bus.nblocks   = 8'd1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            c++;
            #1;
        end
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", c);
            byte_q.delete();
            addr_q.delete();
        end else if (mode == 0) begin
            chk("done_cycle", 32'(c), (n == 0) ? 32'd1 : 32'(17 * n + 1));
        end
        @(negedge clk);
        #1;
        chk("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic reset_mid_xfer();
        int c;
        ready_mode = 0;
        @(negedge clk);
        push_xfer(32'h300, 1);
        bus.start     = 1'b1;
        bus.base_addr = 32'h300;
        bus.nblocks   = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        #1;
        while (byte_q.size() != 11 && c < 40) begin
            @(negedge clk);
            c++;
            #1;
        end
        chk("reached_byte5", 32'(byte_q.size()), 32'd11);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("clr_rd_en", 32'(bus.rd_en), 32'd0);
        chk("clr_tx_data", 32'(bus.tx_data), 32'd0);
        byte_q.delete();
        addr_q.delete();
        @(negedge clk);
        clr = 1'b0;
        run_xfer(32'h300, 1, 0, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk;
        logic [31:0]  rb;
        int           rn;
        int           rm;
        total         = 0;
        bad           = 0;
        ready_mode    = 0;
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = 32'd0;
        bus.nblocks   = 8'd0;

        // Model pins: hand-derived memory contents.
        blk = mem_block(32'h100);
        chk("pin_blk100_w0", blk[31:0], 32'h03020100);
        chk("pin_blk100_w3", blk[127:96], 32'h0f0e0d0c);
        blk = mem_block(32'hFFFF_FFF0);
        chk("pin_blkfff0_b0", 32'(blk[7:0]), 32'h000000f0);
        chk("pin_blkfff0_b15", 32'(blk[127:120]), 32'h000000ff);

        #3;
        chk("rst_rd_addr", bus.rd_addr, 32'd0);
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst_rd_vector", 32'(bus.rd_vector), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;

        run_xfer(32'h100, 1, 0, -1);
        run_xfer(32'h100, 1, 1, -1);
        run_xfer(32'hFFFF_FFF3, 2, 0, -1);
        run_xfer(32'h40, 0, 0, -1);
        run_xfer(32'h100, 2, 0, 5);
        reset_mid_xfer();

        for (int i = 0; i < 20; i++) begin
            rb = $urandom;
            rn = $urandom_range(0, 3);
            rm = $urandom_range(0, 2);
            run_xfer(rb, rn, rm, -1);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_block_reader.md
# dmem_block_reader

Read-side drain engine for the AES data memory. After the CPU stores ciphertext blocks into data memory, this block fetches N consecutive 128-bit blocks through a vector-width read port and streams them out byte by byte on a valid/ready interface, for example towards a UART transmitter or test host. It is the consumer counterpart to the CPU's vector stores: the CPU writes blocks, and this block reads them back out of the chip.

## Interface
Parameters:
- VLEN, 128, data memory vector width in bits; fixed at 128 for this block.
- NB_W, 8, width of the block-count input.

Ports:
- clk  input  1  single clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse; honoured only in IDLE.
- base_addr  input  32  byte address of the first block; bits [3:0] are ignored and treated as 0.
- nblocks  input  NB_W  number of 128-bit blocks to drain.
- rd_addr  output  32  data memory read address; 16-byte aligned.
- rd_en  output  1  read strobe; high only in FETCH.
- rd_vector  output  1  always 1 when rd_en=1 (full VLEN access); 0 otherwise.
- rd_data  input  VLEN  combinational read data for rd_addr, valid in the same cycle.
- tx_data  output  8  output byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - On start=1, latch addr = {base_addr[31:4], 4'b0} and cnt = nblocks.
  - If nblocks = 0, go to DONE. Otherwise go to FETCH.
  - start is ignored in every other state; no queuing.
- FETCH (exactly one cycle):
  - Drive rd_addr = addr, rd_en = 1, rd_vector = 1.
  - At the clock edge, capture rd_data into a 128-bit shift register.
  - Clear the byte index to 0, set addr = addr + 16 (modulo 2^32, wraps silently), set cnt = cnt - 1.
  - Go to SHIFT.
- SHIFT:
  - tx_valid = 1 and tx_data = sreg[7:0]. Bytes leave in little-endian order: byte k = rd_data[8k+7:8k].
  - On tx_valid & tx_ready at an edge, shift sreg right by 8 and increment the byte index.
  - When byte 15 is accepted: go to FETCH if cnt != 0, otherwise go to DONE.
  - While tx_ready = 0, tx_data and tx_valid hold stable.
- DONE (one cycle): done = 1, then go to IDLE.
- Reset: any state goes to IDLE immediately and asynchronously.
  - All outputs are 0: rd_addr, rd_en, rd_vector, tx_data, tx_valid, busy, done.
  - Internal sreg, addr, cnt and byte index are cleared.
  - A transfer interrupted by reset is abandoned; it does not resume.
- The block never writes memory. No write-enable or write-data ports exist.

## Timing
- Cycle 0: start=1 is sampled at the edge ending cycle 0.
- Cycle 1: FETCH; rd_addr = base, rd_en = 1, busy = 1.
- Cycle 2: first tx_valid = 1 with byte 0. Start-to-first-byte latency is 2 cycles.
- With tx_ready held at 1, one byte is accepted per cycle. Each block takes 16 SHIFT cycles plus 1 FETCH bubble.
- Total for N blocks with tx_ready=1: 17N cycles from the first FETCH. DONE occurs in the following cycle, and IDLE in the cycle after that.
- nblocks = 0: DONE in cycle 1 with no memory access and no tx_valid; busy = 1 for that cycle only.
- tx_valid never drops without a handshake. tx_valid = 0 in FETCH, DONE and IDLE.
- A start arriving in the same cycle as done = 1 is ignored. A new start is accepted from IDLE one cycle later.
- An asynchronous clr assertion mid-SHIFT drops tx_valid immediately, without waiting for an edge.

## Test plan
- Single block: memory at 0x100 holds 0x0f0e...0100. Apply start with base=0x100, nblocks=1, tx_ready=1 -> rd_addr=0x100 in cycle 1; bytes 0x00..0x0f in cycles 2..17; done in cycle 18.
- Backpressure: same data, tx_ready toggling 1,0,0,1 repeatedly -> identical byte sequence; tx_data is stable while tx_ready=0; no byte is dropped or duplicated.
- Multi-block with wrap and alignment: base=0xFFFF_FFF3 (masked to 0xFFFF_FFF0), nblocks=2 -> reads at 0xFFFF_FFF0 then 0x0000_0000; 32 bytes out; done after 34 busy cycles.
- Zero count: nblocks=0 -> done in cycle 1; rd_en, rd_vector and tx_valid never go high.
- Start while busy: pulse start=1 with base=0x200 during SHIFT of a transfer from base 0x100 -> ignored; all reads stay at 0x100 onward.
- Reset mid-transfer: assert clr during SHIFT byte 5 -> busy, tx_valid and rd_en are 0 immediately. After release, a new start with nblocks=1 fetches a full fresh block from byte 0.
